password_lock_controller: RTL and testbench

Sequencing controller for the keypad password lock. It turns raw active-low confirm presses on the 4-bit digit switches into enrollment and verification sequences. It stores the enrolled code, compares entered codes, drives the admit pulse, and enforces a retry lockout. It sits between the board pushbutton/switches and the existing seven-segment BCD decoders, which render `digit_value`.

---
 rtl/password_pkg.sv | 25 ++
 rtl/press_sync.sv | 29 ++
 rtl/password_lock_controller.sv | 201 ++++++++++++++++++++
 tb/tb_password_lock_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/password_pkg.sv
// Shared definitions for the keypad password lock.
// Holds the controller state encoding (also used by display/debug logic),
// the digit type, the default code length and a small sizing helper.
package password_pkg;

  localparam int unsigned DefaultDigits = 4;

  typedef logic [3:0] digit_t;

  // Fixed 3-bit encodings so external debug logic can decode the state.
  typedef enum logic [2:0] {
    StEmpty   = 3'd0,
    StEnroll  = 3'd1,
    StReady   = 3'd2,
    StEntry   = 3'd3,
    StCheck   = 3'd4,
    StOpen    = 3'd5,
    StLockout = 3'd6
  } lock_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/press_sync.sv
// Pushbutton synchronizer and press detector.
// Brings an asynchronous active-low button into the clk domain through three
// flops and emits a one-cycle pulse on each high-to-low transition.
//   clk     : clock
//   rst     : asynchronous active-low reset (flops reset to released = 1)
//   btn_n_i : raw active-low button
//   press_o : one-cycle press pulse
module press_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  // sync_q[0] = s0, sync_q[1] = s1, sync_q[2] = s2
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], btn_n_i};
    end
  end

  // Only the falling edge counts, so a held button gives a single press.
  assign press_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/password_lock_controller.sv
// Keypad password lock sequencing controller.
// Enrolls a DIGITS-long code from switch digits, verifies entered codes,
// pulses admitted for ADMIT_CYCLES on a match and locks out for
// LOCKOUT_CYCLES after MAX_TRIES consecutive failures.
//   clk, rst     : clock, asynchronous active-low reset
//   confirm      : raw active-low pushbutton
//   input_data   : digit on the switches, sampled when a press is acted on
//   change_pw    : re-enroll request, honoured on a press while open
//   digit_value  : last captured digit (BCD display)
//   digit_index  : index of the next digit to capture
//   programmed   : a code has been enrolled
//   admitted     : code accepted
//   locked       : retry lockout active
//   fail_count   : consecutive failed checks
module password_lock_controller
  import password_pkg::*;
#(
  parameter int unsigned DIGITS         = DefaultDigits,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned ADMIT_CYCLES   = 100,
  parameter int unsigned LOCKOUT_CYCLES = 500
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             confirm,
  input  logic [3:0]                       input_data,
  input  logic                             change_pw,
  output logic [3:0]                       digit_value,
  output logic [$clog2(DIGITS)-1:0]        digit_index,
  output logic                             programmed,
  output logic                             admitted,
  output logic                             locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

  localparam int unsigned IdxW   = $clog2(DIGITS);
  localparam int unsigned FailW  = $clog2(MAX_TRIES + 1);
  localparam int unsigned TimerW = $clog2(max_u(ADMIT_CYCLES, LOCKOUT_CYCLES));

  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(DIGITS - 1);
  localparam logic [FailW-1:0]  FailLimit = FailW'(MAX_TRIES);
  localparam logic [FailW-1:0]  FailLast  = FailW'(MAX_TRIES - 1);
  localparam logic [TimerW-1:0] AdmitLoad = TimerW'(ADMIT_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLoad  = TimerW'(LOCKOUT_CYCLES - 1);

  logic press;

  lock_state_e        state_q, state_d;
  digit_t             target_q [DIGITS];
  digit_t             target_d [DIGITS];
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               mismatch_q, mismatch_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [FailW-1:0]   fail_q, fail_d;
  logic               programmed_q, programmed_d;
  digit_t             digit_q, digit_d;
  logic               admitted_q, locked_q;

  press_sync u_press_sync (
    .clk     (clk),
    .rst     (rst),
    .btn_n_i (confirm),
    .press_o (press)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    idx_d        = idx_q;
    mismatch_d   = mismatch_q;
    timer_d      = timer_q;
    fail_d       = fail_q;
    programmed_d = programmed_q;
    digit_d      = digit_q;

    case (state_q)
      StEmpty: begin
        if (press) begin
          target_d[0] = input_data;
          digit_d     = input_data;
          idx_d       = IdxW'(1);
          state_d     = StEnroll;
        end
      end

      StEnroll: begin
        if (press) begin
          target_d[idx_q] = input_data;
          digit_d         = input_data;
          if (idx_q == LastIdx) begin
            idx_d        = '0;
            programmed_d = 1'b1;
            state_d      = StReady;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end

      StReady: begin
        if (press) begin
          mismatch_d = (input_data != target_q[0]);
          digit_d    = input_data;
          idx_d      = IdxW'(1);
          state_d    = StEntry;
        end
      end

      StEntry: begin
        if (press) begin
          mismatch_d = mismatch_q | (input_data != target_q[idx_q]);
          digit_d    = input_data;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StCheck;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end

      StCheck: begin
        if (!mismatch_q) begin
          fail_d  = '0;
          timer_d = AdmitLoad;
          state_d = StOpen;
        end else if (fail_q == FailLast) begin
          fail_d  = FailLimit;
          timer_d = LockLoad;
          state_d = StLockout;
        end else begin
          fail_d  = fail_q + FailW'(1);
          state_d = StReady;
        end
      end

      StOpen: begin
        // Expiry wins over a coincident press, which is then dropped.
        if (timer_q == '0) begin
          state_d = StReady;
        end else begin
          timer_d = timer_q - TimerW'(1);
          if (press && change_pw) begin
            idx_d   = '0;
            state_d = StEnroll;
          end
        end
      end

      StLockout: begin
        if (timer_q == '0) begin
          fail_d  = '0;
          state_d = StReady;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StEmpty;
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      timer_q      <= '0;
      fail_q       <= '0;
      programmed_q <= 1'b0;
      digit_q      <= '0;
      admitted_q   <= 1'b0;
      locked_q     <= 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
        target_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      idx_q        <= idx_d;
      mismatch_q   <= mismatch_d;
      timer_q      <= timer_d;
      fail_q       <= fail_d;
      programmed_q <= programmed_d;
      digit_q      <= digit_d;
      // Registered from next state so they track the state exactly.
      admitted_q   <= (state_d == StOpen);
      locked_q     <= (state_d == StLockout);
    end
  end

  assign digit_value = digit_q;
  assign digit_index = idx_q;
  assign programmed  = programmed_q;
  assign admitted    = admitted_q;
  assign locked      = locked_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_password_lock_controller.sv
// Scoreboard bench for password_lock_controller.
module tb_password_lock_controller;

  localparam int unsigned Digits        = 4;
  localparam int unsigned MaxTries      = 3;
  localparam int unsigned AdmitCycles   = 100;
  localparam int unsigned LockoutCycles = 500;

  logic       clk;
  logic       rst;
  logic       confirm;
  logic [3:0] input_data;
  logic       change_pw;
  logic [3:0] digit_value;
  logic [1:0] digit_index;
  logic       programmed;
  logic       admitted;
  logic       locked;
  logic [1:0] fail_count;

  password_lock_controller #(
    .DIGITS         (Digits),
    .MAX_TRIES      (MaxTries),
    .ADMIT_CYCLES   (AdmitCycles),
    .LOCKOUT_CYCLES (LockoutCycles)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .confirm     (confirm),
    .input_data  (input_data),
    .change_pw   (change_pw),
    .digit_value (digit_value),
    .digit_index (digit_index),
    .programmed  (programmed),
    .admitted    (admitted),
    .locked      (locked),
    .fail_count  (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int unsigned {
    SelDigitValue, SelDigitIndex, SelProgrammed, SelAdmitted, SelLocked, SelFailCount
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    int unsigned exp;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int unsigned n_compared;
  int unsigned n_mismatched;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned observe(input sel_e sel);
    case (sel)
      SelDigitValue: return int'(digit_value);
      SelDigitIndex: return int'(digit_index);
      SelProgrammed: return int'(programmed);
      SelAdmitted:   return int'(admitted);
      SelLocked:     return int'(locked);
      SelFailCount:  return int'(fail_count);
      default:       return 0;
    endcase
  endfunction

  task automatic sb_push(input string tag, input sel_e sel, input int unsigned exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_drain();
    sb_item_t it;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      check(it.tag, observe(it.sel), it.exp);
    end
  endtask

  task automatic push_all_zero(input string name);
    sb_push({name, "_dv"},   SelDigitValue, 0);
    sb_push({name, "_idx"},  SelDigitIndex, 0);
    sb_push({name, "_prog"}, SelProgrammed, 0);
    sb_push({name, "_adm"},  SelAdmitted,   0);
    sb_push({name, "_lck"},  SelLocked,     0);
    sb_push({name, "_fail"}, SelFailCount,  0);
  endtask

  // Counts cycles the selected output stays high (bounded), then compares the
  // count with the duration queued beforehand. With poke set, a press is
  // driven part way through to show it is ignored.
  task automatic measure_high(input sel_e sel, input int unsigned bound, input bit poke);
    int unsigned cnt;
    sb_item_t    it;
    cnt = 0;
    while (observe(sel) == 1 && cnt < bound) begin
      if (poke && cnt == 10) begin
        input_data = 4'd9;
        confirm    = 1'b0;
      end
      if (poke && cnt == 20) confirm = 1'b1;
      cnt++;
      @(negedge clk);
    end
    confirm = 1'b1;
    it = sb_q.pop_front();
    check(it.tag, cnt, it.exp);
  endtask

  // Press is acted on at the third rising edge after confirm falls; returns
  // at the falling edge right after that.
  task automatic press(input logic [3:0] d, input logic chg);
    repeat (3) @(negedge clk);
    input_data = d;
    change_pw  = chg;
    confirm    = 1'b0;
    repeat (3) @(negedge clk);
    confirm    = 1'b1;
    change_pw  = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] code, input bit enrolling, input bit prog_before,
                            input string name);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] d;
      d = code[15-4*i -: 4];
      press(d, 1'b0);
      sb_push({name, "_dv"},  SelDigitValue, int'(d));
      sb_push({name, "_idx"}, SelDigitIndex, (i + 1) % 4);
      if (enrolling) sb_push({name, "_prog"}, SelProgrammed, (i == 3) ? 1 : int'(prog_before));
      sb_drain();
    end
  endtask

  task automatic expect_verdict(input int unsigned adm, input int unsigned lck,
                                input int unsigned fail, input string name);
    sb_push({name, "_chk_cycle_adm"}, SelAdmitted, 0);
    sb_drain();
    @(negedge clk);
    sb_push({name, "_adm"},  SelAdmitted,  adm);
    sb_push({name, "_lck"},  SelLocked,    lck);
    sb_push({name, "_fail"}, SelFailCount, fail);
    sb_drain();
  endtask

  task automatic admit_run(input string name);
    sb_push({name, "_admit_len"}, SelAdmitted, AdmitCycles);
    measure_high(SelAdmitted, AdmitCycles + 20, 1'b0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b0;
    confirm      = 1'b1;
    input_data   = 4'd0;
    change_pw    = 1'b0;

    repeat (3) @(negedge clk);
    push_all_zero("reset");
    sb_drain();
    rst = 1'b1;

    // Held button: one capture only.
    @(negedge clk);
    input_data = 4'd7;
    confirm    = 1'b0;
    repeat (50) @(negedge clk);
    confirm = 1'b1;
    repeat (3) @(negedge clk);
    sb_push("held_dv",   SelDigitValue, 7);
    sb_push("held_idx",  SelDigitIndex, 1);
    sb_push("held_prog", SelProgrammed, 0);
    sb_drain();

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Enroll then verify.
    enter_code(16'h1234, 1'b1, 1'b0, "enroll");
    enter_code(16'h1234, 1'b0, 1'b0, "verify");
    expect_verdict(1, 0, 0, "verify");
    admit_run("verify");

    // Lockout after three wrong codes; presses during lockout ignored.
    enter_code(16'h1235, 1'b0, 1'b0, "bad1");
    expect_verdict(0, 0, 1, "bad1");
    enter_code(16'h1235, 1'b0, 1'b0, "bad2");
    expect_verdict(0, 0, 2, "bad2");
    enter_code(16'h1235, 1'b0, 1'b0, "bad3");
    expect_verdict(0, 1, 3, "bad3");
    sb_push("lock_len", SelLocked, LockoutCycles);
    measure_high(SelLocked, LockoutCycles + 20, 1'b1);
    sb_push("post_lock_dv",   SelDigitValue, 5);
    sb_push("post_lock_idx",  SelDigitIndex, 0);
    sb_push("post_lock_fail", SelFailCount,  0);
    sb_push("post_lock_lck",  SelLocked,     0);
    sb_drain();
    enter_code(16'h1234, 1'b0, 1'b0, "after_lock");
    expect_verdict(1, 0, 0, "after_lock");
    admit_run("after_lock");

    // Failure count cleared by a success.
    enter_code(16'h1235, 1'b0, 1'b0, "clr_bad1");
    expect_verdict(0, 0, 1, "clr_bad1");
    enter_code(16'h1235, 1'b0, 1'b0, "clr_bad2");
    expect_verdict(0, 0, 2, "clr_bad2");
    enter_code(16'h1234, 1'b0, 1'b0, "clr_good");
    expect_verdict(1, 0, 0, "clr_good");
    admit_run("clr_good");
    enter_code(16'h1235, 1'b0, 1'b0, "clr_bad3");
    expect_verdict(0, 0, 1, "clr_bad3");

    // Re-enroll from OPEN.
    enter_code(16'h1234, 1'b0, 1'b0, "pre_chg");
    expect_verdict(1, 0, 0, "pre_chg");
    press(4'd0, 1'b1);
    sb_push("chg_adm", SelAdmitted,   0);
    sb_push("chg_idx", SelDigitIndex, 0);
    sb_push("chg_dv",  SelDigitValue, 4);
    sb_drain();
    enter_code(16'h9876, 1'b1, 1'b1, "reenroll");
    enter_code(16'h1234, 1'b0, 1'b0, "old_code");
    expect_verdict(0, 0, 1, "old_code");
    enter_code(16'h9876, 1'b0, 1'b0, "new_code");
    expect_verdict(1, 0, 0, "new_code");
    admit_run("new_code");

    // Reset mid-entry, then a press restarts enrollment.
    press(4'd9, 1'b0);
    press(4'd8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    push_all_zero("mid_rst");
    sb_drain();
    @(negedge clk);
    rst = 1'b1;
    press(4'd5, 1'b0);
    sb_push("restart_dv",   SelDigitValue, 5);
    sb_push("restart_idx",  SelDigitIndex, 1);
    sb_push("restart_prog", SelProgrammed, 0);
    sb_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
